// File: rtl/data_mem_sync.sv
// Single-port synchronous data memory with a self-clearing sweep after reset or on a clear request.
// Define DATA_MEM_SYNC_FWD_EN to forward same-cycle write data onto a read of the same address.
module data_mem_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         dataIn,
  input  logic                     writeEnable,
  input  logic                     readEnable,
  input  logic                     clear,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     readValid,
  output logic                     busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              read_valid_q, read_valid_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              idle;
  logic              addr_ok;
  logic              wr_accept;
  logic [WIDTH-1:0]  rd_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  assign idle      = (state_q == IDLE);
  assign addr_ok   = ({1'b0, addr} < DEPTH_EXT);
  // A clear in the same cycle wins over the write; the sweep will zero the word anyway.
  assign wr_accept = idle & writeEnable & ~clear & addr_ok;

  always_comb begin
    rd_word = '0;
    if (addr_ok) begin
      rd_word = mem[addr];
    end
`ifdef DATA_MEM_SYNC_FWD_EN
    if (wr_accept) begin
      rd_word = dataIn;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    data_out_d   = data_out_q;
    read_valid_d = 1'b0;
    case (state_q)
      SWEEP: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clear) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
        if (readEnable) begin
          data_out_d   = rd_word;
          read_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = SWEEP;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == SWEEP);
  end

  always_comb begin
    mem_we    = (state_q == SWEEP) | wr_accept;
    mem_waddr = idle ? addr : ptr_q;
    mem_wdata = idle ? dataIn : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SWEEP;
      ptr_q        <= '0;
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
      busy_q       <= busy_d;
    end
  end

  // The array itself is never reset; the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign dataOut   = data_out_q;
  assign readValid = read_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_sync.sv
// Directed bench for data_mem_sync: a default 8x256 instance and a 16x100 instance for range checks.
module tb_data_mem_sync;

  logic        clk;
  logic        reset;
  logic [7:0]  addr;
  logic [7:0]  data_in;
  logic        write_enable;
  logic        read_enable;
  logic        clear;
  logic [7:0]  data_out;
  logic        read_valid;
  logic        busy;

  logic        reset_b;
  logic [6:0]  addr_b;
  logic [15:0] data_in_b;
  logic        write_enable_b;
  logic        read_enable_b;
  logic        clear_b;
  logic [15:0] data_out_b;
  logic        read_valid_b;
  logic        busy_b;

  int n_compared;
  int n_mismatched;

  data_mem_sync dut (
    .clk(clk), .reset(reset), .addr(addr), .dataIn(data_in),
    .writeEnable(write_enable), .readEnable(read_enable), .clear(clear),
    .dataOut(data_out), .readValid(read_valid), .busy(busy)
  );

  data_mem_sync #(.WIDTH(16), .DEPTH(100)) dut_b (
    .clk(clk), .reset(reset_b), .addr(addr_b), .dataIn(data_in_b),
    .writeEnable(write_enable_b), .readEnable(read_enable_b), .clear(clear_b),
    .dataOut(data_out_b), .readValid(read_valid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  // Leaves the read result visible on data_out/read_valid for the caller to check.
  task automatic do_read(input logic [7:0] a);
    addr = a; read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
  endtask

  task automatic count_busy(input int expected, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (busy === 1'b0) begin
        n = i;
        break;
      end
    end
    n_compared++;
    if (n !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: busy cycles got %0d expected %0d", name, n, expected);
    end
  endtask

  task automatic test_reset();
    int n, nb;
    reset = 1'b1; reset_b = 1'b1;
    addr = '0; data_in = '0; write_enable = 1'b0; read_enable = 1'b0; clear = 1'b0;
    addr_b = '0; data_in_b = '0; write_enable_b = 1'b0; read_enable_b = 1'b0; clear_b = 1'b0;
    tick();
    tick();
    n_compared++;
    if (data_out !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_dout: got %h expected 00", data_out);
    end
    n_compared++;
    if (read_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid: got %b expected 0", read_valid);
    end
    n_compared++;
    if (busy !== 1'b1 || busy_b !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_busy: got %b/%b expected 1/1", busy, busy_b);
    end
    reset = 1'b0; reset_b = 1'b0;
    n = 0; nb = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (busy === 1'b0 && n == 0) n = i;
      if (busy_b === 1'b0 && nb == 0) nb = i;
      if (n != 0 && nb != 0) break;
    end
    n_compared++;
    if (n !== 256) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_len_256: got %0d expected 256", n);
    end
    n_compared++;
    if (nb !== 100) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_len_100: got %0d expected 100", nb);
    end
  endtask

  task automatic test_read_after_reset();
    logic [7:0] addrs [4];
    addrs = '{8'h00, 8'h10, 8'h7F, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i]);
      n_compared++;
      if (data_out !== 8'h00 || read_valid !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL post_reset_read[%h]: got %h/%b expected 00/1", addrs[i], data_out, read_valid);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(8'h10, 8'hA5);
    do_read(8'h10);
    n_compared++;
    if (data_out !== 8'hA5 || read_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL write_read: got %h/%b expected a5/1", data_out, read_valid);
    end
    tick();
    n_compared++;
    if (read_valid !== 1'b0 || data_out !== 8'hA5) begin
      n_mismatched++;
      $display("[TB] FAIL valid_one_cycle: got %h/%b expected a5/0", data_out, read_valid);
    end
  endtask

  task automatic test_read_during_write();
    logic [7:0] expected;
`ifdef DATA_MEM_SYNC_FWD_EN
    expected = 8'h99;
`else
    expected = 8'h3C;
`endif
    do_write(8'h07, 8'h3C);
    addr = 8'h07; data_in = 8'h99; write_enable = 1'b1; read_enable = 1'b1;
    tick();
    write_enable = 1'b0; read_enable = 1'b0;
    n_compared++;
    if (data_out !== expected || read_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL rdw_same_addr: got %h/%b expected %h/1", data_out, read_valid, expected);
    end
    do_read(8'h07);
    n_compared++;
    if (data_out !== 8'h99) begin
      n_mismatched++;
      $display("[TB] FAIL rdw_write_landed: got %h expected 99", data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) do_write(8'(i + 1), vals[i]);
    read_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i + 1);
      tick();
      n_compared++;
      if (data_out !== vals[i] || read_valid !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_read[%0d]: got %h/%b expected %h/1", i, data_out, read_valid, vals[i]);
      end
    end
    read_enable = 1'b0;
    tick();
    n_compared++;
    if (read_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_valid_drop: got %b expected 0", read_valid);
    end
  endtask

  task automatic test_clear();
    int n;
    do_write(8'h20, 8'h5A);
    // Clear, write and read together: the write is dropped, the read sees pre-sweep data.
    addr = 8'h20; data_in = 8'hFF; clear = 1'b1; write_enable = 1'b1; read_enable = 1'b1;
    tick();
    clear = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    n_compared++;
    if (data_out !== 8'h5A || read_valid !== 1'b1 || busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL clear_same_cycle: got %h/%b/%b expected 5a/1/1", data_out, read_valid, busy);
    end
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      if (i >= 10 && i <= 14) begin
        addr = 8'h02; data_in = 8'h77; write_enable = 1'b1; read_enable = 1'b1; clear = 1'b1;
      end else begin
        write_enable = 1'b0; read_enable = 1'b0; clear = 1'b0;
      end
      tick();
      if (i >= 10 && i <= 14) begin
        n_compared++;
        if (read_valid !== 1'b0 || data_out !== 8'h5A) begin
          n_mismatched++;
          $display("[TB] FAIL sweep_ignores_rw[%0d]: got %h/%b expected 5a/0", i, data_out, read_valid);
        end
      end
      if (busy === 1'b0) begin
        n = i;
        break;
      end
    end
    write_enable = 1'b0; read_enable = 1'b0; clear = 1'b0;
    n_compared++;
    if (n !== 256) begin
      n_mismatched++;
      $display("[TB] FAIL clear_sweep_len: got %0d expected 256", n);
    end
    do_read(8'h10);
    n_compared++;
    if (data_out !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL cleared_10: got %h expected 00", data_out);
    end
    do_read(8'h20);
    n_compared++;
    if (data_out !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL cleared_20: got %h expected 00", data_out);
    end
    do_read(8'h02);
    n_compared++;
    if (data_out !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL sweep_write_dropped: got %h expected 00", data_out);
    end
  endtask

  task automatic test_reset_mid_read();
    do_write(8'h05, 8'h42);
    do_read(8'h05);
    n_compared++;
    if (data_out !== 8'h42 || read_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL pre_reset_read: got %h/%b expected 42/1", data_out, read_valid);
    end
    reset = 1'b1;
    #1;
    n_compared++;
    if (read_valid !== 1'b0 || data_out !== 8'h00 || busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset_read: got %h/%b/%b expected 00/0/1", data_out, read_valid, busy);
    end
    tick();
    reset = 1'b0;
    count_busy(256, "mid_read_sweep_len");
  endtask

  task automatic test_reset_mid_sweep();
    do_write(8'hF0, 8'h66);
    do_read(8'hF0);
    n_compared++;
    if (data_out !== 8'h66) begin
      n_mismatched++;
      $display("[TB] FAIL pre_sweep_read: got %h expected 66", data_out);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    reset = 1'b1;
    #1;
    n_compared++;
    if (read_valid !== 1'b0 || data_out !== 8'h00 || busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_mid_sweep: got %h/%b/%b expected 00/0/1", data_out, read_valid, busy);
    end
    tick();
    tick();
    reset = 1'b0;
    count_busy(256, "restart_sweep_len");
    do_read(8'hF0);
    n_compared++;
    if (data_out !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL restart_swept_f0: got %h expected 00", data_out);
    end
  endtask

  task automatic test_out_of_range();
    int bad;
    addr_b = 7'd120; data_in_b = 16'h1234; write_enable_b = 1'b1;
    tick();
    write_enable_b = 1'b0;
    bad = 0;
    read_enable_b = 1'b1;
    for (int i = 0; i < 100; i++) begin
      addr_b = 7'(i);
      tick();
      n_compared++;
      if (data_out_b !== 16'h0000 || read_valid_b !== 1'b1) begin
        n_mismatched++;
        bad++;
        if (bad <= 4) $display("[TB] FAIL oor_no_alias[%0d]: got %h/%b expected 0000/1", i, data_out_b, read_valid_b);
      end
    end
    read_enable_b = 1'b0;
    addr_b = 7'd99; data_in_b = 16'hBEEF; write_enable_b = 1'b1;
    tick();
    write_enable_b = 1'b0; read_enable_b = 1'b1;
    tick();
    n_compared++;
    if (data_out_b !== 16'hBEEF) begin
      n_mismatched++;
      $display("[TB] FAIL last_word_99: got %h expected beef", data_out_b);
    end
    addr_b = 7'd120;
    tick();
    read_enable_b = 1'b0;
    n_compared++;
    if (data_out_b !== 16'h0000 || read_valid_b !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL oor_read_120: got %h/%b expected 0000/1", data_out_b, read_valid_b);
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    $display("[TB] starting data_mem_sync bench");
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_read_during_write();
    test_back_to_back();
    test_clear();
    test_reset_mid_read();
    test_reset_mid_sweep();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
